// File: rtl/dds_sweep_ctl.sv
// DDS frequency sweep controller: steps a tuning word from start to stop,
// handshaking each point with the DDS and holding it for a dwell period.
module dds_sweep_ctl #(
  parameter int unsigned FW = 32,
  parameter int unsigned DW = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          continuous,
  input  logic [FW-1:0] start_word,
  input  logic [FW-1:0] stop_word,
  input  logic [FW-1:0] step_word,
  input  logic [DW-1:0] dwell,
  input  logic          upd_ack,
  output logic [FW-1:0] frq_word,
  output logic          upd_req,
  output logic          busy,
  output logic          done,
  output logic [15:0]   pt_idx
);

  typedef enum logic [1:0] {IDLE, REQ, DWELL} state_t;

  state_t        state, state_nxt;
  logic [FW-1:0] sh_start, sh_stop, sh_step;
  logic [DW-1:0] sh_dwell, cnt, dwell_m1;
  logic          sh_cont;
  logic [FW:0]   next_sum;
  logic          last_dwell, sweep_end;
  logic          do_load, do_ack, do_adv, do_wrap, do_done;

  assign upd_req = (state == REQ);
  assign busy    = (state != IDLE);

  always_comb begin
    state_nxt  = state;
    do_load    = 1'b0;
    do_ack     = 1'b0;
    do_adv     = 1'b0;
    do_wrap    = 1'b0;
    do_done    = 1'b0;
    // frq_word doubles as the current sweep point
    next_sum   = {1'b0, frq_word} + {1'b0, sh_step};
    last_dwell = (cnt == '0);
    sweep_end  = (frq_word == sh_stop) || (sh_step == '0) || (frq_word > sh_stop);
    dwell_m1   = (sh_dwell == '0) ? '0 : sh_dwell - DW'(1);
    case (state)
      IDLE: begin
        if (start) begin
          do_load   = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (upd_ack) begin
          do_ack    = 1'b1;
          state_nxt = DWELL;
        end
      end
      DWELL: begin
        if (last_dwell) begin
          if (sweep_end) begin
            do_done = 1'b1;
            if (sh_cont) begin
              do_wrap   = 1'b1;
              state_nxt = REQ;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            do_adv    = 1'b1;
            state_nxt = REQ;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    // abort overrides every other event in the same cycle
    if (abort) begin
      state_nxt = IDLE;
      do_load   = 1'b0;
      do_ack    = 1'b0;
      do_adv    = 1'b0;
      do_wrap   = 1'b0;
      do_done   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      frq_word <= '0;
      pt_idx   <= '0;
      cnt      <= '0;
      done     <= 1'b0;
      sh_start <= '0;
      sh_stop  <= '0;
      sh_step  <= '0;
      sh_dwell <= '0;
      sh_cont  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= do_done;
      if (do_load) begin
        sh_start <= start_word;
        sh_stop  <= stop_word;
        sh_step  <= step_word;
        sh_dwell <= dwell;
        sh_cont  <= continuous;
        frq_word <= start_word;
        pt_idx   <= '0;
      end
      if (do_ack) begin
        cnt <= dwell_m1;
      end else if (state == DWELL && !last_dwell) begin
        cnt <= cnt - DW'(1);
      end
      // carry out of the add counts as overshoot, clamping to stop
      if (do_adv) begin
        frq_word <= (next_sum > {1'b0, sh_stop}) ? sh_stop : next_sum[FW-1:0];
        pt_idx   <= pt_idx + 16'd1;
      end
      if (do_wrap) begin
        frq_word <= sh_start;
        pt_idx   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctl.sv
// Randomized bench for dds_sweep_ctl against an arithmetic model of the
// expected tuning-word list and handshake/dwell timing.
module tb_dds_sweep_ctl;
  localparam int unsigned FW = 32;
  localparam int unsigned DW = 20;

  logic          clk = 1'b0;
  logic          rst, start, abort, continuous, upd_ack;
  logic [FW-1:0] start_word, stop_word, step_word, frq_word;
  logic [DW-1:0] dwell;
  logic          upd_req, busy, done;
  logic [15:0]   pt_idx;

  int     n_vec = 0;
  int     n_err = 0;
  longint exp_q[$];

  always #5 clk = ~clk;

  dds_sweep_ctl #(.FW(FW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .continuous(continuous),
    .start_word(start_word), .stop_word(stop_word), .step_word(step_word),
    .dwell(dwell), .upd_ack(upd_ack), .frq_word(frq_word), .upd_req(upd_req),
    .busy(busy), .done(done), .pt_idx(pt_idx)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected list of words: start, then start+k*step clamped to stop.
  function automatic void build(input longint s, input longint p, input longint st);
    longint c;
    c = s;
    exp_q.delete();
    exp_q.push_back(c);
    while (!(c == p || st == 0 || c > p)) begin
      c = c + st;
      if (c > p) c = p;
      exp_q.push_back(c);
    end
  endfunction

  task automatic scramble_inputs;
    start_word = $urandom;
    stop_word  = $urandom;
    step_word  = $urandom;
    dwell      = DW'($urandom);
    continuous = 1'($urandom);
  endtask

  // Runs a sweep; in continuous mode n_pts points are visited and the
  // controller is left in REQ for the caller.
  task automatic run_sweep(input logic [FW-1:0] s, input logic [FW-1:0] p,
                           input logic [FW-1:0] st, input logic [DW-1:0] dw,
                           input bit cont, input int n_pts,
                           input int dmin, input int dmax);
    int dcyc, n, k, d;
    logic [FW-1:0] held;
    dcyc = (dw == 0) ? 1 : int'(dw);
    build(longint'(s), longint'(p), longint'(st));
    n = exp_q.size();
    if (!cont) n_pts = n;
    start_word = s; stop_word = p; step_word = st; dwell = dw; continuous = cont;
    start = 1'b1;
    tick;
    start = 1'b0;
    scramble_inputs;
    check("busy_after_start", busy, 1);
    for (int i = 0; i < n_pts; i++) begin
      k = i % n;
      upd_ack = 1'b0;
      check("upd_req", upd_req, 1);
      check("frq_word", frq_word, exp_q[k]);
      check("pt_idx", pt_idx, 64'(k));
      check("done_at_point", done, 64'(i > 0 && k == 0));
      held = frq_word;
      d = int'($urandom_range(dmin, dmax));
      for (int j = 0; j < d; j++) begin
        start = 1'($urandom);
        scramble_inputs;
        tick;
        check("hold_req", upd_req, 1);
        check("hold_word", frq_word, 64'(held));
      end
      start = 1'b0;
      upd_ack = 1'b1;
      tick;
      for (int j = 0; j < dcyc; j++) begin
        check("dwell_req", upd_req, 0);
        check("dwell_busy", busy, 1);
        check("dwell_done", done, 0);
        upd_ack = 1'($urandom);
        start = 1'($urandom);
        scramble_inputs;
        tick;
      end
      upd_ack = 1'b0;
      start = 1'b0;
    end
    if (!cont) begin
      check("end_done", done, 1);
      check("end_busy", busy, 0);
      check("end_req", upd_req, 0);
      check("end_word", frq_word, exp_q[n-1]);
      tick;
      check("done_pulse_width", done, 0);
      check("idle_word_hold", frq_word, exp_q[n-1]);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [FW-1:0] s, p, st;
    rst = 1'b1; start = 1'b0; abort = 1'b0; continuous = 1'b0; upd_ack = 1'b0;
    start_word = '1; stop_word = '1; step_word = '1; dwell = '1;
    tick; tick;
    check("rst_word", frq_word, 0);
    check("rst_idx", pt_idx, 0);
    check("rst_req", upd_req, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    tick;

    run_sweep(100, 300, 100, 3, 0, 0, 1, 1);
    run_sweep(100, 250, 100, 2, 0, 0, 0, 2);
    run_sweep(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 1, 0, 0, 0, 2);
    run_sweep(500, 200, 7, 0, 0, 0, 0, 1);
    run_sweep(1234, 5000, 0, 0, 0, 0, 0, 1);
    run_sweep(40, 70, 10, 2, 0, 0, 10, 10);

    // Continuous, then abort together with ack and a start request
    run_sweep(10, 30, 10, 2, 1, 8, 0, 2);
    abort = 1'b1; upd_ack = 1'b1; start = 1'b1;
    tick;
    abort = 1'b0; upd_ack = 1'b0; start = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_req", upd_req, 0);
    check("abort_done", done, 0);
    tick;
    check("abort_done_late", done, 0);
    check("abort_idle", busy, 0);

    // Abort during DWELL on the final point
    run_sweep(5, 5, 1, 4, 1, 1, 0, 0);
    upd_ack = 1'b1; tick; upd_ack = 1'b0;
    tick; tick; tick;
    abort = 1'b1; tick; abort = 1'b0;
    check("abort_dwell_busy", busy, 0);
    check("abort_dwell_done", done, 0);

    // Reset in the middle of DWELL
    run_sweep(300, 900, 50, 5, 1, 1, 0, 0);
    upd_ack = 1'b1; tick; upd_ack = 1'b0;
    tick; tick;
    rst = 1'b1; tick; rst = 1'b0;
    check("rst_mid_word", frq_word, 0);
    check("rst_mid_idx", pt_idx, 0);
    check("rst_mid_req", upd_req, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    tick;
    check("rst_mid_done_late", done, 0);

    for (int r = 0; r < 20; r++) begin
      s = $urandom;
      if ($urandom % 4 == 0) begin
        s = 32'hFFFF_F000 | ($urandom & 32'hFFF);
        p = 32'hFFFF_FFFF - (($urandom % 2 == 0) ? 32'd0 : 32'($urandom_range(0, 100)));
      end else begin
        p = s + 32'($urandom_range(0, 3000));
      end
      st = 32'($urandom_range(0, 800));
      if (st != 0 && st < 80) st = 80;
      if ($urandom % 8 == 0) st = 0;
      run_sweep(s, p, st, DW'($urandom_range(0, 4)), 0, 0, 0, 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
